// File: rtl/fetch_unit_pkg.sv
// Shared widths, reset vector and fetch FSM encoding for the instruction-fetch stage.
package fetch_unit_pkg;
  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;
  localparam logic [W_ADDR-1:0] RESET_VECTOR = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  function automatic logic [W_ADDR-1:0] seq_pc(input logic [W_ADDR-1:0] pc);
    return pc + W_ADDR'(4);
  endfunction
endpackage

// File: rtl/redirect_latch.sv
// Holds a taken-branch target until the delay slot hands off, and resolves next_pc.
module redirect_latch
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              branch,
  input  logic [W_ADDR-1:0] branch_addr,
  input  logic              handoff,
  input  logic              flush,
  input  logic [W_ADDR-1:0] pc,
  output logic              redir_v,
  output logic [W_ADDR-1:0] redir_addr,
  output logic [W_ADDR-1:0] next_pc
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_v    <= 1'b0;
      redir_addr <= '0;
    end else if (flush || handoff) begin
      redir_v    <= 1'b0;
    end else if (branch) begin
      redir_v    <= 1'b1;
      redir_addr <= branch_addr;
    end
  end

  // A live branch wins over the latch: it is the same target, just not yet stored.
  assign next_pc = branch ? branch_addr : redir_v ? redir_addr : seq_pc(pc);
endmodule

// File: rtl/fetch_unit.sv
// MIPS IF stage: PC owner, req/addr_ok/data_ok fetch port, IF/ID handoff.
// Optional FETCH_ADEL_EN: misaligned PCs skip memory and present a nop flagged if_adel.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [W_ADDR-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [W_ADDR-1:0] flush_addr,
  input  logic              branch,
  input  logic [W_ADDR-1:0] branch_addr,
  output logic              inst_req,
  output logic [W_ADDR-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [W_DATA-1:0] inst_rdata,
  output logic              if_valid,
  output logic [W_ADDR-1:0] if_pc,
  output logic [W_DATA-1:0] if_inst,
  output logic              if_adel
);
  fetch_state_t      state, state_n;
  logic [W_ADDR-1:0] pc, pc_n, out_pc, out_pc_n;
  logic [W_DATA-1:0] out_inst, out_inst_n;
  logic              handoff, misaligned;
  logic              redir_v;
  logic [W_ADDR-1:0] redir_addr, next_pc;
  logic              unused_redir;

`ifdef FETCH_ADEL_EN
  logic out_adel;
  assign misaligned = |pc[1:0];
  assign inst_addr  = pc;
  assign if_adel    = out_adel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                out_adel <= 1'b0;
    else if (flush)                         out_adel <= 1'b0;
    else if (state == S_REQ && misaligned)  out_adel <= 1'b1;
    else if (state == S_WAIT && inst_data_ok) out_adel <= 1'b0;
  end
`else
  assign misaligned = 1'b0;
  assign inst_addr  = {pc[W_ADDR-1:2], 2'b00};
  assign if_adel    = 1'b0;
`endif

  assign inst_req = !rst && state == S_REQ && !misaligned;
  assign if_valid = state == S_HOLD;
  assign if_pc    = out_pc;
  assign if_inst  = out_inst;
  assign handoff  = state == S_HOLD && !stall && !flush;

  redirect_latch u_redir (
    .clk        (clk),
    .rst        (rst),
    .branch     (branch),
    .branch_addr(branch_addr),
    .handoff    (handoff),
    .flush      (flush),
    .pc         (pc),
    .redir_v    (redir_v),
    .redir_addr (redir_addr),
    .next_pc    (next_pc)
  );
  // Latch contents are only consumed through next_pc; kept as named nets for debug.
  assign unused_redir = ^{redir_v, redir_addr};

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    out_pc_n   = out_pc;
    out_inst_n = out_inst;
    if (flush) begin
      pc_n       = flush_addr;
      out_pc_n   = '0;
      out_inst_n = '0;
      // An accepted-but-unanswered request must still be drained in S_DROP.
      case (state)
        S_REQ:   state_n = (inst_req && inst_addr_ok) ? S_DROP : S_REQ;
        S_WAIT:  state_n = inst_data_ok ? S_REQ : S_DROP;
        S_DROP:  state_n = inst_data_ok ? S_REQ : S_DROP;
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (misaligned) begin
            state_n    = S_HOLD;
            out_pc_n   = pc;
            out_inst_n = '0;
          end else if (inst_addr_ok) begin
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            state_n    = S_HOLD;
            out_pc_n   = pc;
            out_inst_n = inst_rdata;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_n    = next_pc;
            state_n = S_REQ;
          end
        end
        S_DROP:  if (inst_data_ok) state_n = S_REQ;
        default: state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      out_pc   <= '0;
      out_inst <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      out_pc   <= out_pc_n;
      out_inst <= out_inst_n;
    end
  end
endmodule
